// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor.
//   - btb_entry_t : one BTB line (valid, tag, target, is_jump)
//   - SNT/WNT/WT/ST : 2-bit saturating counter encodings
//   - bp_index/bp_tag : PC slicing for a given index width
// Tag and target fields use the widest supported PC (BpMaxXlen). Narrower PCs are
// zero-extended on write and compared or truncated in full on read.
package bp_pkg;

    localparam int unsigned BpMaxXlen = 64;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    typedef struct packed {
        logic                 valid;
        logic [BpMaxXlen-1:0] tag;
        logic [BpMaxXlen-1:0] target;
        logic                 is_jump;
    } btb_entry_t;

    // pc[idx_w+1:2], zero-extended.
    function automatic logic [BpMaxXlen-1:0] bp_index(input logic [BpMaxXlen-1:0] pc,
                                                      input int unsigned idx_w);
        return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
    endfunction

    // pc[XLEN-1:idx_w+2], zero-extended.
    function automatic logic [BpMaxXlen-1:0] bp_tag(input logic [BpMaxXlen-1:0] pc,
                                                    input int unsigned idx_w);
        return pc >> (idx_w + 2);
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup, EX resolution and statistics bundle of the branch predictor.
//   master : pipeline side (drives pc_fe and the upd_* resolution fields)
//   slave  : predictor side (drives pred_*, mispredict and the counters)
interface branch_predictor_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned IDX   = 4,
    parameter int unsigned CNT_W = 32
);
    logic [XLEN-1:0]  pc_fe;
    logic             pred_hit;
    logic             pred_taken;
    logic [XLEN-1:0]  pred_target;
    logic [IDX-1:0]   pred_pht_idx;

    logic             upd_valid;
    logic [XLEN-1:0]  upd_pc;
    logic             upd_is_jump;
    logic             upd_taken;
    logic [XLEN-1:0]  upd_target;
    logic             upd_pred_taken;
    logic [XLEN-1:0]  upd_pred_target;
    logic [IDX-1:0]   upd_pht_idx;

    logic             mispredict;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispredict_cnt;

    modport master (
        output pc_fe, upd_valid, upd_pc, upd_is_jump, upd_taken, upd_target,
               upd_pred_taken, upd_pred_target, upd_pht_idx,
        input  pred_hit, pred_taken, pred_target, pred_pht_idx, mispredict,
               branch_cnt, mispredict_cnt
    );

    modport slave (
        input  pc_fe, upd_valid, upd_pc, upd_is_jump, upd_taken, upd_target,
               upd_pred_taken, upd_pred_target, upd_pht_idx,
        output pred_hit, pred_taken, pred_target, pred_pht_idx, mispredict,
               branch_cnt, mispredict_cnt
    );

endinterface

// File: rtl/bp_sat_ctr.sv
// 2-bit saturating up/down counter next-state logic.
//   ctr_i : current counter value
//   inc_i : 1 = count up (taken), 0 = count down (not taken)
//   ctr_o : next counter value, clamped to SNT..ST
module bp_sat_ctr
    import bp_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       inc_i,
    output logic [1:0] ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (inc_i) begin
            if (ctr_i != ST) ctr_o = ctr_i + 2'd1;
        end else begin
            if (ctr_i != SNT) ctr_o = ctr_i - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB + 2-bit PHT branch predictor with statistics counters.
//   clk, rst_n : core clock, asynchronous active-low reset
//   bp (slave) : pc_fe lookup -> pred_hit/pred_taken/pred_target/pred_pht_idx,
//                EX resolution upd_* -> training, mispredict, branch_cnt/mispredict_cnt
// Optional build macro BRANCH_PREDICTOR_GSHARE_EN: XOR a non-speculative global
// history register into the PHT index. The bp interface instance must use
// XLEN/IDX/CNT_W matching this module (IDX = $clog2(ENTRIES)), XLEN <= 64.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned CNT_W   = 32
) (
    input logic              clk,
    input logic              rst_n,
    branch_predictor_if.slave bp
);

    localparam int unsigned IDX = $clog2(ENTRIES);

    btb_entry_t       btb_q [ENTRIES];
    logic [1:0]       pht_q [ENTRIES];
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

    // ---------------- Lookup (combinational, pre-update state) ----------------
    logic [IDX-1:0]       lk_idx, lk_pht_idx;
    logic [BpMaxXlen-1:0] lk_tag;
    logic                 lk_hit;

    assign lk_idx = IDX'(bp_index(64'(bp.pc_fe), IDX));
    assign lk_tag = bp_tag(64'(bp.pc_fe), IDX);
    assign lk_hit = btb_q[lk_idx].valid && (btb_q[lk_idx].tag == lk_tag);

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    logic [IDX-1:0] ghr_q;
    assign lk_pht_idx = lk_idx ^ ghr_q;
`else
    assign lk_pht_idx = lk_idx;
`endif

    assign bp.pred_hit     = lk_hit;
    assign bp.pred_taken   = lk_hit && (btb_q[lk_idx].is_jump || pht_q[lk_pht_idx][1]);
    assign bp.pred_target  = lk_hit ? XLEN'(btb_q[lk_idx].target) : '0;
    assign bp.pred_pht_idx = lk_pht_idx;

    // Wrong direction, or right "taken" direction with a stale target.
    assign bp.mispredict = bp.upd_valid &&
                           ((bp.upd_pred_taken != bp.upd_taken) ||
                            (bp.upd_taken && (bp.upd_pred_target != bp.upd_target)));

    // ---------------- Training ----------------
    logic [IDX-1:0]       upd_idx;
    logic [BpMaxXlen-1:0] upd_tag;
    logic                 upd_hit;
    logic                 upd_cond;
    logic [1:0]           pht_trained;
    btb_entry_t           btb_entry_d;
    logic                 btb_we, pht_we;
    logic [1:0]           pht_d;

    assign upd_idx  = IDX'(bp_index(64'(bp.upd_pc), IDX));
    assign upd_tag  = bp_tag(64'(bp.upd_pc), IDX);
    assign upd_hit  = btb_q[upd_idx].valid && (btb_q[upd_idx].tag == upd_tag);
    assign upd_cond = !bp.upd_is_jump;

    bp_sat_ctr u_sat_ctr (
        .ctr_i (pht_q[bp.upd_pht_idx]),
        .inc_i (bp.upd_taken),
        .ctr_o (pht_trained)
    );

    always_comb begin
        btb_entry_d = '{valid: 1'b1, tag: upd_tag, target: 64'(bp.upd_target),
                        is_jump: bp.upd_is_jump};
        btb_we      = 1'b0;
        pht_we      = 1'b0;
        pht_d       = pht_trained;
        if (bp.upd_valid) begin
            if (upd_hit) begin
                // Tag/valid unchanged on a hit, so rewriting the whole line only
                // refreshes target and is_jump.
                btb_we = bp.upd_taken;
                pht_we = upd_cond;
            end else if (bp.upd_taken) begin
                btb_we = 1'b1;
                pht_we = upd_cond;
                pht_d  = WT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                btb_q[i] <= '0;
                pht_q[i] <= WNT;
            end
        end else begin
            if (btb_we) btb_q[upd_idx] <= btb_entry_d;
            if (pht_we) pht_q[bp.upd_pht_idx] <= pht_d;
        end
    end

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_q <= '0;
        end else if (bp.upd_valid && upd_cond) begin
            ghr_q <= {ghr_q[IDX-2:0], bp.upd_taken};
        end
    end
`endif

    // ---------------- Statistics (saturating) ----------------
    always_comb begin
        branch_cnt_d = branch_cnt_q;
        mis_cnt_d    = mis_cnt_q;
        if (bp.upd_valid && (branch_cnt_q != '1)) branch_cnt_d = branch_cnt_q + CNT_W'(1);
        if (bp.mispredict && (mis_cnt_q != '1))   mis_cnt_d    = mis_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_q <= '0;
            mis_cnt_q    <= '0;
        end else begin
            branch_cnt_q <= branch_cnt_d;
            mis_cnt_q    <= mis_cnt_d;
        end
    end

    assign bp.branch_cnt     = branch_cnt_q;
    assign bp.mispredict_cnt = mis_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor (ENTRIES=16): directed steps followed by
// randomized resolutions, checked against a behavioural BTB/PHT model.
module tb_branch_predictor;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ENT  = 16;
    localparam int unsigned IDX  = 4;
    localparam int unsigned CW   = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_predictor_if #(.XLEN(XLEN), .IDX(IDX), .CNT_W(CW)) bif ();

    branch_predictor #(.XLEN(XLEN), .ENTRIES(ENT), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bif)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model: entries addressed by (pc/4) mod ENT, tag = pc/(4*ENT).
    bit              m_valid [ENT];
    int unsigned     m_tag   [ENT];
    logic [31:0]     m_tgt   [ENT];
    bit              m_jump  [ENT];
    int              m_ctr   [ENT];
    int unsigned     m_ghr;
    longint unsigned m_bcnt, m_mcnt;

    function automatic int unsigned m_index(input logic [31:0] pc);
        return (pc / 4) % ENT;
    endfunction

    function automatic int unsigned m_tagof(input logic [31:0] pc);
        return pc / (4 * ENT);
    endfunction

    function automatic int unsigned m_pidx(input logic [31:0] pc);
        return m_index(pc) ^ m_ghr;
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[m_index(pc)] && (m_tag[m_index(pc)] == m_tagof(pc));
    endfunction

    function automatic bit m_taken(input logic [31:0] pc);
        return m_hit(pc) && (m_jump[m_index(pc)] || (m_ctr[m_pidx(pc)] >= 2));
    endfunction

    function automatic logic [31:0] m_target(input logic [31:0] pc);
        return m_hit(pc) ? m_tgt[m_index(pc)] : 32'd0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < ENT; i++) begin
            m_valid[i] = 0;
            m_tag[i]   = 0;
            m_tgt[i]   = 0;
            m_jump[i]  = 0;
            m_ctr[i]   = 1;
        end
        m_ghr  = 0;
        m_bcnt = 0;
        m_mcnt = 0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_lookup(input string pfx);
        logic [31:0] pc;
        pc = bif.pc_fe;
        chk({pfx, ".hit"},    64'(bif.pred_hit),     64'(m_hit(pc)));
        chk({pfx, ".taken"},  64'(bif.pred_taken),   64'(m_taken(pc)));
        chk({pfx, ".target"}, 64'(bif.pred_target),  64'(m_target(pc)));
        chk({pfx, ".pidx"},   64'(bif.pred_pht_idx), 64'(m_pidx(pc)));
    endtask

    task automatic chk_counters(input string pfx);
        chk({pfx, ".bcnt"}, 64'(bif.branch_cnt),     m_bcnt);
        chk({pfx, ".mcnt"}, 64'(bif.mispredict_cnt), m_mcnt);
    endtask

    // Called #1 after a posedge. Drives one resolution, checks the same-cycle
    // lookup (pre-update) and mispredict, then clocks it in and updates the model.
    task automatic do_upd(input string pfx, input logic [31:0] pc, input bit jump,
                          input bit taken, input logic [31:0] tgt, input bit ptaken,
                          input logic [31:0] ptgt);
        bit          mis, hit;
        int unsigned i, pi;
        pi                  = m_pidx(pc);
        bif.upd_valid       = 1'b1;
        bif.upd_pc          = pc;
        bif.upd_is_jump     = jump;
        bif.upd_taken       = taken;
        bif.upd_target      = tgt;
        bif.upd_pred_taken  = ptaken;
        bif.upd_pred_target = ptgt;
        bif.upd_pht_idx     = IDX'(pi);
        #1;
        mis = (ptaken != taken) || (taken && (ptgt != tgt));
        chk({pfx, ".mis"}, 64'(bif.mispredict), 64'(mis));
        chk_lookup({pfx, ".pre"});
        @(posedge clk);
        #1;
        bif.upd_valid = 1'b0;
        i   = m_index(pc);
        hit = m_hit(pc);
        m_bcnt++;
        if (mis) m_mcnt++;
        if (hit) begin
            if (!jump) m_ctr[pi] = taken ? ((m_ctr[pi] < 3) ? m_ctr[pi] + 1 : 3)
                                         : ((m_ctr[pi] > 0) ? m_ctr[pi] - 1 : 0);
            if (taken) begin
                m_tgt[i]  = tgt;
                m_jump[i] = jump;
            end
        end else if (taken) begin
            m_valid[i] = 1;
            m_tag[i]   = m_tagof(pc);
            m_tgt[i]   = tgt;
            m_jump[i]  = jump;
            if (!jump) m_ctr[pi] = 2;
        end
`ifdef BRANCH_PREDICTOR_GSHARE_EN
        if (!jump) m_ghr = ((m_ghr << 1) | 32'(taken)) % ENT;
`endif
        chk_counters({pfx, ".post"});
    endtask

    task automatic look(input logic [31:0] pc);
        bif.pc_fe = pc;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc, tgt, ptgt;
        bit          jump, taken, ptaken;

        m_reset();
        bif.pc_fe = 32'h40;
        bif.upd_valid = 0; bif.upd_pc = 0; bif.upd_is_jump = 0; bif.upd_taken = 0;
        bif.upd_target = 0; bif.upd_pred_taken = 0; bif.upd_pred_target = 0;
        bif.upd_pht_idx = 0;
        #12 rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset state
        chk("rst.hit",    64'(bif.pred_hit), 0);
        chk("rst.taken",  64'(bif.pred_taken), 0);
        chk("rst.target", 64'(bif.pred_target), 0);
        chk_counters("rst");

        // Allocation on taken conditional; same-cycle lookup of 0x40 still misses
        do_upd("alloc", 32'h40, 0, 1, 32'h100, 0, 0);
        look(32'h40);
        chk("alloc.hit",    64'(bif.pred_hit), 1);
        chk("alloc.taken",  64'(bif.pred_taken), 1);
        chk("alloc.target", 64'(bif.pred_target), 64'h100);

        // Two not-taken -> counter bottoms out, still a hit
        do_upd("nt1", 32'h40, 0, 0, 32'h44, 1, 32'h100);
        do_upd("nt2", 32'h40, 0, 0, 32'h44, 0, 0);
        look(32'h40);
        chk("nt.hit",   64'(bif.pred_hit), 1);
        chk("nt.taken", 64'(bif.pred_taken), 0);

        // Four taken -> saturate at 3; one not-taken afterwards still predicts taken
        for (int k = 0; k < 4; k++) do_upd("sat", 32'h40, 0, 1, 32'h100, 0, 32'h100);
        do_upd("satnt", 32'h40, 0, 0, 32'h44, 1, 32'h100);
        look(32'h40);
        chk("sat.taken", 64'(bif.pred_taken), 1);

        // Aliasing on index 0
        look(32'h80);
        chk("alias.miss", 64'(bif.pred_hit), 0);
        do_upd("alias", 32'h80, 0, 1, 32'h200, 0, 0);
        look(32'h80);
        chk("alias.hit",    64'(bif.pred_hit), 1);
        chk("alias.target", 64'(bif.pred_target), 64'h200);
        look(32'h40);
        chk("alias.evict", 64'(bif.pred_hit), 0);
        do_upd("noalloc", 32'h300, 0, 0, 32'h304, 0, 0);
        look(32'h300);
        chk("noalloc.miss", 64'(bif.pred_hit), 0);
        look(32'h80);
        chk("noalloc.keep", 64'(bif.pred_hit), 1);

        // JAL: mispredicted, then correctly predicted
        look(32'h44);
        do_upd("jal1", 32'h44, 1, 1, 32'h10, 0, 0);
        look(32'h44);
        chk("jal.hit",    64'(bif.pred_hit), 1);
        chk("jal.taken",  64'(bif.pred_taken), 1);
        chk("jal.target", 64'(bif.pred_target), 64'h10);
        do_upd("jal2", 32'h44, 1, 1, 32'h10, 1, 32'h10);
        chk("jal2.mis", 64'(bif.mispredict), 0);

        // Randomized resolutions over a small PC space to force aliasing
        for (int n = 0; n < 300; n++) begin
            pc    = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 7) << 2);
            jump  = ($urandom_range(0, 4) == 0);
            taken = jump ? 1'b1 : 1'($urandom_range(0, 1));
            tgt   = $urandom_range(0, 255) << 2;
            if ($urandom_range(0, 3) != 0) begin
                ptaken = m_taken(pc);
                ptgt   = m_target(pc);
            end else begin
                ptaken = 1'($urandom_range(0, 1));
                ptgt   = $urandom_range(0, 255) << 2;
            end
            bif.pc_fe = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 7) << 2);
            do_upd("rnd", pc, jump, taken, tgt, ptaken, ptgt);
        end

        // Asynchronous reset in the middle of an update cycle
        do_upd("prerst", 32'h40, 0, 1, 32'h100, 0, 0);
        bif.pc_fe           = 32'h40;
        bif.upd_valid       = 1'b1;
        bif.upd_pc          = 32'h40;
        bif.upd_is_jump     = 1'b0;
        bif.upd_taken       = 1'b1;
        bif.upd_target      = 32'h100;
        bif.upd_pred_taken  = 1'b0;
        bif.upd_pred_target = 32'h0;
        bif.upd_pht_idx     = IDX'(m_pidx(32'h40));
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        chk("arst.hit",    64'(bif.pred_hit), 0);
        chk("arst.taken",  64'(bif.pred_taken), 0);
        chk("arst.target", 64'(bif.pred_target), 0);
        chk("arst.mis",    64'(bif.mispredict), 1);
        chk_counters("arst");
        #1;
        bif.upd_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        look(32'h40);
        chk("arst.miss40", 64'(bif.pred_hit), 0);
        chk_counters("arst.after");

`ifdef BRANCH_PREDICTOR_GSHARE_EN
        chk("ghr.rst", 64'(dut.ghr_q), 0);
        do_upd("g1", 32'h40, 0, 1, 32'h100, 0, 0);
        do_upd("g2", 32'h48, 0, 0, 32'h4c, 0, 0);
        do_upd("g3", 32'h50, 0, 1, 32'h180, 0, 0);
        chk("ghr.tnt", 64'(dut.ghr_q), 64'(m_ghr));
        chk("ghr.101", 64'(dut.ghr_q), 64'b0101);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
